// File: rtl/rotate_round_scheduler_if.sv
// rotate_round_scheduler_if
// Request/result bundle for the two-port rotate scheduler.
// master: host side (request queues + output consumer); slave: the scheduler.
interface rotate_round_scheduler_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_data;
    logic [2:0] req0_key;
    logic       req0_dec;

    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_data;
    logic [2:0] req1_key;
    logic       req1_dec;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_id;
    logic       busy;

    modport master (
        output req0_valid, req0_data, req0_key, req0_dec,
        output req1_valid, req1_data, req1_key, req1_dec,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req0_valid, req0_data, req0_key, req0_dec,
        input  req1_valid, req1_data, req1_key, req1_dec,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/rotate_round_scheduler.sv
// rotate_round_scheduler
// Round-robin arbiter for two requesters feeding one 8-bit rotate stage.
// An accepted byte runs ROUNDS rounds; round n rotates by (key + n) mod 8.
// Optional feature macro: ROTATE_SCHED_DECRYPT_EN -- when defined, reqN_dec
// selects rotate-right; when undefined every job rotates left.
//
// state | meaning
// IDLE  | waiting for a request, arbitrating, ready to accept
// RUN   | applying one rotate round per cycle
// DONE  | result held on the output port until out_ready
module rotate_round_scheduler #(
    parameter int ROUNDS = 4
) (
    input logic                      clk,
    input logic                      rst,
    rotate_round_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_last;
    logic       r_id;
    logic       r_dec;
    logic [2:0] r_key;
    logic [3:0] r_rnd;
    logic [7:0] r_acc;

    logic       w_any;
    logic       w_grant;
    logic       w_accept;
    logic       w_last_round;
    logic       w_sel_dec;
    logic [2:0] w_rk;
    logic [7:0] w_rotl;
    logic [7:0] w_rotr;
    logic [7:0] w_rot;

    // Round-robin grant: on a tie the requester that did not win last goes next.
    always_comb begin
        w_any   = bus.req0_valid | bus.req1_valid;
        w_grant = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
`ifdef ROTATE_SCHED_DECRYPT_EN
        w_sel_dec = w_grant ? bus.req1_dec : bus.req0_dec;
`else
        // dec pins stay on the interface but every job is forced to encrypt.
        w_sel_dec = 1'b0 & (w_grant ? bus.req1_dec : bus.req0_dec);
`endif
    end

    // Per-round key and rotation; shifting an 8-bit value by 8 yields zero,
    // so a zero round key passes the byte through unchanged.
    always_comb begin
        w_rk         = r_key + r_rnd[2:0];
        w_rotl       = (r_acc << w_rk) | (r_acc >> (4'd8 - {1'b0, w_rk}));
        w_rotr       = (r_acc >> w_rk) | (r_acc << (4'd8 - {1'b0, w_rk}));
        w_rot        = r_dec ? w_rotr : w_rotl;
        w_last_round = (r_rnd == 4'(ROUNDS - 1));
    end

    // State register; reset drops any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and port outputs; the result is only driven while held in DONE.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = 8'h00;
        bus.out_id     = 1'b0;
        bus.busy       = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                bus.req0_ready = bus.req0_valid & ~w_grant;
                bus.req1_ready = bus.req1_valid & w_grant;
                w_accept       = w_any;
                if (w_any) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last_round) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = r_acc;
                bus.out_id    = r_id;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Job datapath: latch the granted request on accept, then rotate each RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= 8'h00;
            r_rnd  <= 4'd0;
            r_key  <= 3'd0;
            r_dec  <= 1'b0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_acc  <= w_grant ? bus.req1_data : bus.req0_data;
            r_key  <= w_grant ? bus.req1_key : bus.req0_key;
            r_dec  <= w_sel_dec;
            r_id   <= w_grant;
            r_last <= w_grant;
            r_rnd  <= 4'd0;
        end else if (r_state == RUN) begin
            r_acc  <= w_rot;
            r_rnd  <= r_rnd + 4'd1;
        end
    end

endmodule

// File: tb/tb_rotate_round_scheduler.sv
// Bench for rotate_round_scheduler: a ROUNDS=4 instance carries most scenarios,
// a ROUNDS=1 instance covers the single-round boundary.
module tb_rotate_round_scheduler;

    logic clk;
    logic rst;

    rotate_round_scheduler_if ifa ();
    rotate_round_scheduler_if ifb ();

    rotate_round_scheduler #(.ROUNDS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(ifa.slave));
    rotate_round_scheduler #(.ROUNDS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct packed {
        logic [7:0] data;
        logic       id;
    } exp_t;

    exp_t sbq_a[$];
    exp_t sbq_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: net rotation (R*key + R*(R-1)/2) mod 8, applied bit by bit.
    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] k,
                                         input logic dec, input int r);
        int         amt;
        logic [7:0] res;
        amt = (r * int'(k) + (r * (r - 1)) / 2) % 8;
`ifndef ROTATE_SCHED_DECRYPT_EN
        dec = 1'b0;
`endif
        res = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (!dec) res[(i + amt) % 8] = d[i];
            else      res[i] = d[(i + amt) % 8];
        end
        return res;
    endfunction

    function automatic exp_t pop_a();
        exp_t e;
        e = 'x;
        if (sbq_a.size() > 0) e = sbq_a.pop_front();
        return e;
    endfunction

    function automatic exp_t pop_b();
        exp_t e;
        e = 'x;
        if (sbq_b.size() > 0) e = sbq_b.pop_front();
        return e;
    endfunction

    // Scoreboard push on every accept handshake, using the values presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.req0_valid && ifa.req0_ready)
                sbq_a.push_back({model(ifa.req0_data, ifa.req0_key, ifa.req0_dec, 4), 1'b0});
            if (ifa.req1_valid && ifa.req1_ready)
                sbq_a.push_back({model(ifa.req1_data, ifa.req1_key, ifa.req1_dec, 4), 1'b1});
            if (ifb.req0_valid && ifb.req0_ready)
                sbq_b.push_back({model(ifb.req0_data, ifb.req0_key, ifb.req0_dec, 1), 1'b0});
            if (ifb.req1_valid && ifb.req1_ready)
                sbq_b.push_back({model(ifb.req1_data, ifb.req1_key, ifb.req1_dec, 1), 1'b1});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one request on ifa for a single edge, then scramble the inputs.
    task automatic send_a(input bit port, input logic [7:0] d, input logic [2:0] k, input bit dec);
        if (!port) begin
            ifa.req0_valid = 1'b1; ifa.req0_data = d; ifa.req0_key = k; ifa.req0_dec = dec;
        end else begin
            ifa.req1_valid = 1'b1; ifa.req1_data = d; ifa.req1_key = k; ifa.req1_dec = dec;
        end
        @(posedge clk); #1;
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
        ifa.req0_data = ~d; ifa.req1_data = ~d;
        ifa.req0_key = k + 3'd3; ifa.req1_key = k + 3'd3;
        ifa.req0_dec = ~dec; ifa.req1_dec = ~dec;
    endtask

    task automatic wait_valid_a(input int maxc, output int cyc);
        cyc = 0;
        while (!ifa.out_valid && cyc < maxc) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", ifa.out_valid); else n_pass++;
        n_checks++; if (ifa.out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", ifa.out_data); else n_pass++;
        n_checks++; if (ifa.out_id !== 1'b0) $display("FAIL reset_out_id got=%b exp=0", ifa.out_id); else n_pass++;
        n_checks++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", ifa.busy); else n_pass++;
        n_checks++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {ifa.req0_ready, ifa.req1_ready}); else n_pass++;
        n_checks++; if (ifb.out_valid !== 1'b0 || ifb.busy !== 1'b0) $display("FAIL reset_r1_idle got=%b%b exp=00", ifb.out_valid, ifb.busy); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int   cyc;
        exp_t e;
        send_a(1'b0, 8'h81, 3'd0, 1'b0);
        wait_valid_a(20, cyc);
        n_checks++; if (!ifa.out_valid || cyc != 4) $display("FAIL basic_latency got=%0d valid=%b exp=4", cyc, ifa.out_valid); else n_pass++;
        e = pop_a();
        n_checks++; if (ifa.out_data !== e.data) $display("FAIL basic_sb_data got=%h exp=%h", ifa.out_data, e.data); else n_pass++;
        n_checks++; if (ifa.out_id !== e.id) $display("FAIL basic_sb_id got=%b exp=%b", ifa.out_id, e.id); else n_pass++;
        n_checks++; if (ifa.out_data !== 8'h60) $display("FAIL basic_data got=%h exp=60", ifa.out_data); else n_pass++;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        n_checks++; if (ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) $display("FAIL basic_release got=%b%b exp=00", ifa.out_valid, ifa.busy); else n_pass++;
    endtask

    task automatic test_req1_enc_dec();
        int         cyc;
        exp_t       e;
        logic [7:0] exp_dec;
`ifdef ROTATE_SCHED_DECRYPT_EN
        exp_dec = 8'h96;
`else
        exp_dec = 8'h69;
`endif
        send_a(1'b1, 8'h96, 3'd1, 1'b0);
        wait_valid_a(20, cyc);
        n_checks++; if (!ifa.out_valid || cyc != 4) $display("FAIL enc1_latency got=%0d exp=4", cyc); else n_pass++;
        e = pop_a();
        n_checks++; if (ifa.out_data !== e.data || ifa.out_id !== e.id) $display("FAIL enc1_sb got=%h/%b exp=%h/%b", ifa.out_data, ifa.out_id, e.data, e.id); else n_pass++;
        n_checks++; if (ifa.out_data !== 8'h5A || ifa.out_id !== 1'b1) $display("FAIL enc1_data got=%h/%b exp=5a/1", ifa.out_data, ifa.out_id); else n_pass++;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;

        send_a(1'b1, 8'h5A, 3'd1, 1'b1);
        wait_valid_a(20, cyc);
        n_checks++; if (!ifa.out_valid) $display("FAIL dec1_timeout got=%0d cycles exp=4", cyc); else n_pass++;
        e = pop_a();
        n_checks++; if (ifa.out_data !== e.data || ifa.out_id !== e.id) $display("FAIL dec1_sb got=%h/%b exp=%h/%b", ifa.out_data, ifa.out_id, e.data, e.id); else n_pass++;
        n_checks++; if (ifa.out_data !== exp_dec) $display("FAIL dec1_data got=%h exp=%h", ifa.out_data, exp_dec); else n_pass++;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   got;
        int   cyc;
        exp_t e;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq_a.delete();
        ifa.req0_valid = 1'b1; ifa.req0_data = 8'h11; ifa.req0_key = 3'd2; ifa.req0_dec = 1'b0;
        ifa.req1_valid = 1'b1; ifa.req1_data = 8'hC3; ifa.req1_key = 3'd6; ifa.req1_dec = 1'b0;
        ifa.out_ready  = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 80) begin
            n_checks++; if (ifa.req0_ready && ifa.req1_ready) $display("FAIL b2b_both_ready cycle=%0d got=11 exp=not both", cyc); else n_pass++;
            if (ifa.out_valid && ifa.out_ready) begin
                e = pop_a();
                n_checks++; if (ifa.out_data !== e.data || ifa.out_id !== e.id) $display("FAIL b2b_sb job=%0d got=%h/%b exp=%h/%b", got, ifa.out_data, ifa.out_id, e.data, e.id); else n_pass++;
                n_checks++; if (ifa.out_id !== got[0]) $display("FAIL b2b_order job=%0d got=%b exp=%b", got, ifa.out_id, got[0]); else n_pass++;
                got++;
                if (got == 4) begin
                    ifa.req0_valid = 1'b0;
                    ifa.req1_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        ifa.req0_valid = 1'b0;
        ifa.req1_valid = 1'b0;
        ifa.out_ready  = 1'b0;
        n_checks++; if (got != 4) $display("FAIL b2b_jobs got=%0d exp=4", got); else n_pass++;
        n_checks++; if (cyc != 24) $display("FAIL b2b_period got=%0d cycles exp=24", cyc); else n_pass++;
    endtask

    task automatic test_stall();
        int   cyc;
        int   bad;
        exp_t e;
        send_a(1'b1, 8'h3C, 3'd5, 1'b0);
        wait_valid_a(20, cyc);
        n_checks++; if (!ifa.out_valid || cyc != 4) $display("FAIL stall_latency got=%0d exp=4", cyc); else n_pass++;
        e = pop_a();
        ifa.req0_valid = 1'b1; ifa.req0_data = 8'h77; ifa.req0_key = 3'd1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_data !== e.data || ifa.out_id !== e.id ||
                ifa.busy !== 1'b1 || ifa.req0_ready !== 1'b0 || ifa.req1_ready !== 1'b0) begin
                $display("FAIL stall_hold cycle=%0d got=v%b d%h id%b b%b r%b%b exp=v1 d%h id%b b1 r00",
                         i, ifa.out_valid, ifa.out_data, ifa.out_id, ifa.busy, ifa.req0_ready, ifa.req1_ready, e.data, e.id);
                bad++;
            end else n_pass++;
            @(posedge clk); #1;
        end
        ifa.req0_valid = 1'b0;
        ifa.out_ready  = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready  = 1'b0;
        n_checks++; if (ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) $display("FAIL stall_release got=%b%b exp=00", ifa.out_valid, ifa.busy); else n_pass++;
    endtask

    task automatic test_reset_mid_job();
        int   cyc;
        exp_t e;
        send_a(1'b0, 8'hA5, 3'd3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        n_checks++; if (ifa.busy !== 1'b1) $display("FAIL abort_busy_before got=%b exp=1", ifa.busy); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) $display("FAIL abort_immediate got=%b%b exp=00", ifa.out_valid, ifa.busy); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq_a.delete();
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifa.out_valid !== 1'b0) cyc++;
            @(posedge clk); #1;
        end
        n_checks++; if (cyc != 0) $display("FAIL abort_no_output got=%0d valid cycles exp=0", cyc); else n_pass++;
        send_a(1'b1, 8'h0F, 3'd2, 1'b0);
        wait_valid_a(20, cyc);
        n_checks++; if (!ifa.out_valid || cyc != 4) $display("FAIL after_abort_latency got=%0d exp=4", cyc); else n_pass++;
        e = pop_a();
        n_checks++; if (ifa.out_data !== e.data || ifa.out_id !== e.id) $display("FAIL after_abort_sb got=%h/%b exp=%h/%b", ifa.out_data, ifa.out_id, e.data, e.id); else n_pass++;
        n_checks++; if (ifa.out_data !== 8'hC3) $display("FAIL after_abort_data got=%h exp=c3", ifa.out_data); else n_pass++;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_single_round();
        int   cyc;
        exp_t e;
        ifb.req0_valid = 1'b1; ifb.req0_data = 8'h01; ifb.req0_key = 3'd7; ifb.req0_dec = 1'b0;
        @(posedge clk); #1;
        ifb.req0_valid = 1'b0; ifb.req0_data = 8'hFE;
        cyc = 0;
        while (!ifb.out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (!ifb.out_valid || cyc != 1) $display("FAIL r1_latency got=%0d exp=1", cyc); else n_pass++;
        e = pop_b();
        n_checks++; if (ifb.out_data !== e.data || ifb.out_id !== e.id) $display("FAIL r1_sb got=%h/%b exp=%h/%b", ifb.out_data, ifb.out_id, e.data, e.id); else n_pass++;
        n_checks++; if (ifb.out_data !== 8'h80) $display("FAIL r1_data got=%h exp=80", ifb.out_data); else n_pass++;
        ifb.out_ready = 1'b1;
        @(posedge clk); #1;
        ifb.out_ready = 1'b0;
        n_checks++; if (ifb.out_valid !== 1'b0) $display("FAIL r1_release got=%b exp=0", ifb.out_valid); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        ifa.req0_valid = 1'b0; ifa.req0_data = 8'h00; ifa.req0_key = 3'd0; ifa.req0_dec = 1'b0;
        ifa.req1_valid = 1'b0; ifa.req1_data = 8'h00; ifa.req1_key = 3'd0; ifa.req1_dec = 1'b0;
        ifa.out_ready  = 1'b0;
        ifb.req0_valid = 1'b0; ifb.req0_data = 8'h00; ifb.req0_key = 3'd0; ifb.req0_dec = 1'b0;
        ifb.req1_valid = 1'b0; ifb.req1_data = 8'h00; ifb.req1_key = 3'd0; ifb.req1_dec = 1'b0;
        ifb.out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_req1_enc_dec();
        test_back_to_back();
        test_stall();
        test_reset_mid_job();
        test_single_round();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
